// File: rtl/saa_wb_collector_if.sv
// Bus bundle for saa_wb_collector: per-lane SA write-back inputs and the single
// output-SRAM write port. The collector uses the slave view; the SA array and SRAM use master.
interface saa_wb_collector_if #(
    parameter int SA_NUM = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic [SA_NUM-1:0]        wb_valid;
    logic [SA_NUM*ADDR_W-1:0] wb_addr;
    logic [SA_NUM*DATA_W-1:0] wb_data;
    logic [SA_NUM-1:0]        wb_almost_full;
    logic                     sram_w_en;
    logic [ADDR_W-1:0]        sram_w_addr;
    logic [DATA_W-1:0]        sram_w_data;
    logic                     sram_w_ready;

    modport slave (
        input  wb_valid, wb_addr, wb_data, sram_w_ready,
        output wb_almost_full, sram_w_en, sram_w_addr, sram_w_data
    );

    modport master (
        output wb_valid, wb_addr, wb_data, sram_w_ready,
        input  wb_almost_full, sram_w_en, sram_w_addr, sram_w_data
    );
endinterface

// File: rtl/saa_wb_collector.sv
// Write-back collector: per-lane FIFOs drained round-robin into one registered SRAM write slot.
// Optional error tracking (overflow flags, drop counter) is enabled by defining SAA_WB_ERR_EN.
module saa_wb_collector #(
    parameter int SA_NUM     = 4,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    saa_wb_collector_if.slave bus,
    input  logic              err_clr,
    output logic              wb_idle,
    output logic [SA_NUM-1:0] wb_overflow,
    output logic [7:0]        wb_drop_cnt
);
    localparam int LANE_W  = $clog2(SA_NUM);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] AF_CNT   = (PTR_W+1)'(FIFO_DEPTH - 1);

    logic [ENTRY_W-1:0] fifo_mem [SA_NUM][FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr   [SA_NUM];
    logic [PTR_W:0]     rd_ptr   [SA_NUM];
    logic [PTR_W:0]     fifo_cnt [SA_NUM];
    logic [PTR_W:0]     cnt_next [SA_NUM];

    logic [SA_NUM-1:0]  fifo_full;
    logic [SA_NUM-1:0]  fifo_empty;
    logic [SA_NUM-1:0]  push;
    logic [SA_NUM-1:0]  pop;
    logic [SA_NUM-1:0]  drop;
    logic [SA_NUM-1:0]  almost_full_q;

    logic [LANE_W-1:0]  rr_ptr;
    logic [LANE_W-1:0]  grant_idx;
    logic [LANE_W-1:0]  scan_idx;
    logic               grant_valid;
    logic               slot_load;
    logic [ENTRY_W-1:0] head_entry;

    logic               en_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;

    // The extra pointer bit separates full from empty when the index bits match.
    always_comb begin
        fifo_full  = '0;
        fifo_empty = '0;
        for (int i = 0; i < SA_NUM; i++) begin
            fifo_cnt[i]   = wr_ptr[i] - rd_ptr[i];
            fifo_empty[i] = (wr_ptr[i] == rd_ptr[i]);
            fifo_full[i]  = (fifo_cnt[i] == FULL_CNT);
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < SA_NUM; k++) begin
            scan_idx = rr_ptr + LANE_W'(k);
            if (!grant_valid && !fifo_empty[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign slot_load  = !en_q || bus.sram_w_ready;
    assign head_entry = fifo_mem[grant_idx][rd_ptr[grant_idx][PTR_W-1:0]];

    // A full lane can still accept a push in the cycle its head is popped.
    always_comb begin
        push = '0;
        pop  = '0;
        drop = '0;
        for (int i = 0; i < SA_NUM; i++) begin
            pop[i]      = slot_load && grant_valid && (grant_idx == LANE_W'(i));
            push[i]     = bus.wb_valid[i] && (!fifo_full[i] || pop[i]);
            drop[i]     = bus.wb_valid[i] && fifo_full[i] && !pop[i];
            cnt_next[i] = fifo_cnt[i] + (PTR_W+1)'(push[i]) - (PTR_W+1)'(pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < SA_NUM; i++) begin
            if (push[i]) begin
                fifo_mem[i][wr_ptr[i][PTR_W-1:0]] <= {bus.wb_addr[i*ADDR_W +: ADDR_W],
                                                      bus.wb_data[i*DATA_W +: DATA_W]};
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            almost_full_q <= '0;
            for (int i = 0; i < SA_NUM; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SA_NUM; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + (PTR_W+1)'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + (PTR_W+1)'(1);
                almost_full_q[i] <= (cnt_next[i] >= AF_CNT);
            end
        end
    end

    // The slot only reloads once its current write is accepted; otherwise it holds.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            rr_ptr <= '0;
        end else if (slot_load) begin
            en_q <= grant_valid;
            if (grant_valid) begin
                addr_q <= head_entry[ENTRY_W-1:DATA_W];
                data_q <= head_entry[DATA_W-1:0];
                rr_ptr <= grant_idx + LANE_W'(1);
            end
        end
    end

    assign bus.sram_w_en      = en_q;
    assign bus.sram_w_addr    = addr_q;
    assign bus.sram_w_data    = data_q;
    assign bus.wb_almost_full = almost_full_q;
    assign wb_idle            = (&fifo_empty) && !en_q;

`ifdef SAA_WB_ERR_EN
    logic [SA_NUM-1:0] overflow_q;
    logic [7:0]        drop_cnt_q;
    logic [15:0]       drop_sum;

    always_comb begin
        drop_sum = {8'd0, drop_cnt_q};
        for (int i = 0; i < SA_NUM; i++) begin
            drop_sum = drop_sum + 16'(drop[i]);
        end
    end

    // Clear takes priority, so a drop coinciding with err_clr is not recorded.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_q <= '0;
            drop_cnt_q <= '0;
        end else if (err_clr) begin
            overflow_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_q | drop;
            drop_cnt_q <= (drop_sum > 16'd255) ? 8'hFF : drop_sum[7:0];
        end
    end

    assign wb_overflow = overflow_q;
    assign wb_drop_cnt = drop_cnt_q;
`else
    logic unused_err;
    assign unused_err  = ^{err_clr, drop};
    assign wb_overflow = '0;
    assign wb_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_saa_wb_collector.sv
// Directed self-checking bench for saa_wb_collector; overflow expectations follow SAA_WB_ERR_EN.
module tb_saa_wb_collector;
    localparam int SA_NUM     = 4;
    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        err_clr;
    logic        wb_idle;
    logic [3:0]  wb_overflow;
    logic [7:0]  wb_drop_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [27:0] wr_log[$];
    logic [27:0] exp_log[$];
    logic [7:0]  exp_drop;
    logic [3:0]  exp_ovf;

    saa_wb_collector_if #(.SA_NUM(SA_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    saa_wb_collector #(
        .SA_NUM(SA_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus),
        .err_clr(err_clr),
        .wb_idle(wb_idle),
        .wb_overflow(wb_overflow),
        .wb_drop_cnt(wb_drop_cnt)
    );

    always #5 clk = ~clk;

    // Record every completed SRAM handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (resetn === 1'b1 && bus.sram_w_en === 1'b1 && bus.sram_w_ready === 1'b1)
            wr_log.push_back({bus.sram_w_addr, bus.sram_w_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int lane, input logic v, input logic [11:0] a, input logic [15:0] d);
        bus.wb_valid[lane]                  = v;
        bus.wb_addr[lane*ADDR_W +: ADDR_W] = a;
        bus.wb_data[lane*DATA_W +: DATA_W] = d;
    endtask

    task automatic clearInputs();
        bus.wb_valid = '0;
    endtask

    task automatic doReset();
        resetn = 1'b0;
        clearInputs();
        tick();
        tick();
        resetn = 1'b1;
        wr_log.delete();
    endtask

    task automatic waitWrites(input string tag, input int n);
        for (int c = 0; c < 40 && wr_log.size() < n; c++) tick();
        checkOutput({tag, " write count"}, wr_log.size(), n);
    endtask

    task automatic checkLog(input string tag);
        checkOutput({tag, " log size"}, wr_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++)
            checkOutput($sformatf("%s entry %0d", tag, i), wr_log[i], exp_log[i]);
        wr_log.delete();
        exp_log.delete();
    endtask

    initial begin
        resetn           = 1'b0;
        err_clr          = 1'b0;
        bus.sram_w_ready = 1'b1;
        bus.wb_valid     = '0;
        bus.wb_addr      = '0;
        bus.wb_data      = '0;
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("reset en", bus.sram_w_en, 1'b0);
        checkOutput("reset addr", bus.sram_w_addr, 12'h000);
        checkOutput("reset data", bus.sram_w_data, 16'h0000);
        checkOutput("reset almost_full", bus.wb_almost_full, 4'b0000);
        checkOutput("reset idle", wb_idle, 1'b1);
        checkOutput("reset overflow", wb_overflow, 4'b0000);
        checkOutput("reset drop_cnt", wb_drop_cnt, 8'd0);
        resetn = 1'b1;
        tick();

        $display("[TB] single write on lane 2");
        applyStimulus(2, 1'b1, 12'h010, 16'h00AB);
        tick();
        clearInputs();
        checkOutput("single N+1 en", bus.sram_w_en, 1'b0);
        checkOutput("single N+1 idle", wb_idle, 1'b0);
        tick();
        checkOutput("single N+2 en", bus.sram_w_en, 1'b1);
        checkOutput("single N+2 addr", bus.sram_w_addr, 12'h010);
        checkOutput("single N+2 data", bus.sram_w_data, 16'h00AB);
        tick();
        checkOutput("single N+3 en", bus.sram_w_en, 1'b0);
        checkOutput("single N+3 idle", wb_idle, 1'b1);
        exp_log.push_back({12'h010, 16'h00AB});
        checkLog("single");

        $display("[TB] all lanes simultaneously");
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 12'h100 + 12'(i), 16'h0200 + 16'(i));
        tick();
        clearInputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("simul en %0d", i), bus.sram_w_en, 1'b1);
            checkOutput($sformatf("simul addr %0d", i), bus.sram_w_addr, 12'h100 + 12'(i));
            exp_log.push_back({12'h100 + 12'(i), 16'h0200 + 16'(i)});
        end
        tick();
        checkOutput("simul done en", bus.sram_w_en, 1'b0);
        checkLog("simul");

        $display("[TB] backpressure on lane 0");
        doReset();
        bus.sram_w_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1'b1, 12'h300 + 12'(k), 16'h0400 + 16'(k));
            exp_log.push_back({12'h300 + 12'(k), 16'h0400 + 16'(k)});
            tick();
            if (k == 2) begin
                checkOutput("bp hold en", bus.sram_w_en, 1'b1);
                checkOutput("bp hold addr k2", bus.sram_w_addr, 12'h300);
                checkOutput("bp almost_full 2 entries", bus.wb_almost_full[0], 1'b0);
            end
            if (k == 3) checkOutput("bp almost_full 3 entries", bus.wb_almost_full[0], 1'b1);
            if (k == 4) begin
                checkOutput("bp hold addr k4", bus.sram_w_addr, 12'h300);
                checkOutput("bp hold data k4", bus.sram_w_data, 16'h0400);
            end
        end
        clearInputs();
        bus.sram_w_ready = 1'b1;
        waitWrites("bp", 5);
        checkOutput("bp drop_cnt", wb_drop_cnt, 8'd0);
        checkLog("bp");

        $display("[TB] overflow on lane 1");
        doReset();
        bus.sram_w_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) bus.sram_w_ready = 1'b0;
            applyStimulus(1, 1'b1, 12'h500 + 12'(k), 16'h0600 + 16'(k));
            if (k < 6) exp_log.push_back({12'h500 + 12'(k), 16'h0600 + 16'(k)});
            tick();
        end
`ifdef SAA_WB_ERR_EN
        exp_drop = 8'd2;
        exp_ovf  = 4'b0010;
`else
        exp_drop = 8'd0;
        exp_ovf  = 4'b0000;
`endif
        checkOutput("ovf drop_cnt", wb_drop_cnt, exp_drop);
        checkOutput("ovf flags", wb_overflow, exp_ovf);
        checkOutput("ovf almost_full", bus.wb_almost_full, 4'b0010);
        err_clr = 1'b1;
        applyStimulus(1, 1'b1, 12'h5FF, 16'h06FF);
        tick();
        err_clr = 1'b0;
        clearInputs();
        checkOutput("clr drop_cnt", wb_drop_cnt, 8'd0);
        checkOutput("clr flags", wb_overflow, 4'b0000);
        bus.sram_w_ready = 1'b1;
        waitWrites("ovf", 6);
        tick();
        checkOutput("ovf drained idle", wb_idle, 1'b1);
        checkLog("ovf");

        $display("[TB] fairness lanes 0 and 3");
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1'b1, 12'h600 + 12'(k), 16'h0800 + 16'(k));
            applyStimulus(3, 1'b1, 12'h700 + 12'(k), 16'h0900 + 16'(k));
            exp_log.push_back({12'h600 + 12'(k), 16'h0800 + 16'(k)});
            exp_log.push_back({12'h700 + 12'(k), 16'h0900 + 16'(k)});
            tick();
        end
        clearInputs();
        waitWrites("fair", 8);
        checkLog("fair");

        $display("[TB] reset mid-stream");
        doReset();
        bus.sram_w_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 12'hA00 + 12'(i), 16'h0B00 + 16'(i));
        tick();
        clearInputs();
        tick();
        checkOutput("midrst before en", bus.sram_w_en, 1'b1);
        resetn = 1'b0;
        #1;
        checkOutput("midrst en", bus.sram_w_en, 1'b0);
        checkOutput("midrst idle", wb_idle, 1'b1);
        checkOutput("midrst addr", bus.sram_w_addr, 12'h000);
        tick();
        resetn           = 1'b1;
        bus.sram_w_ready = 1'b1;
        tick();
        checkOutput("midrst first cycle en", bus.sram_w_en, 1'b0);
        repeat (4) tick();
        checkOutput("midrst no stale writes", wr_log.size(), 0);
        checkOutput("midrst idle after", wb_idle, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
